ctl_classifier: RTL

CTL_CLASSIFIER -- requirements
Module: ctl_classifier

---
 rtl/ctl_classifier.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/ctl_classifier.sv
// ---------------------------------------------------------------------------
// ctl_classifier
// Watches the main-control bundle of a single-cycle MIPS-style datapath. It
// rebuilds the opcode that produced the bundle, classifies it as R / lw / sw /
// beq / j / illegal, and keeps a saturating event counter per class. One
// counter can be read back through a registered select port.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous active-high reset (wins over everything else)
//   ctl_valid  bundle below is valid this cycle
//   RegDst, Jump, ALUsrc, Memto_Reg, RegWrite, RegRead, MemWrite, Branch,
//   ALUop[1:0] control bundle under observation
//   op_valid   op_code / op_class are valid (1 cycle after ctl_valid)
//   op_code    reconstructed 6-bit opcode (111111 for an illegal bundle)
//   op_class   0=R 1=lw 2=sw 3=beq 4=j 5=illegal
//   cnt_clr    clears all counters and the error flag
//   cnt_sel    counter read select (0..5, 6..7 read as zero)
//   cnt_data   registered value of the selected counter
//   err        sticky illegal-bundle flag
//
// Build option
//   CTL_CLASSIFIER_TRAP_EN  when defined, the first illegal bundle sets err and
//                           freezes counters 0..4 until cnt_clr or rst; the
//                           illegal counter keeps counting. When undefined,
//                           err stays 0 and counting never freezes.
// ---------------------------------------------------------------------------
module ctl_classifier #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             ctl_valid,
   input  logic             RegDst,
   input  logic             Jump,
   input  logic             ALUsrc,
   input  logic             Memto_Reg,
   input  logic             RegWrite,
   input  logic             RegRead,
   input  logic             MemWrite,
   input  logic             Branch,
   input  logic [1:0]       ALUop,
   output logic             op_valid,
   output logic [5:0]       op_code,
   output logic [2:0]       op_class,
   input  logic             cnt_clr,
   input  logic [2:0]       cnt_sel,
   output logic [CNT_W-1:0] cnt_data,
   output logic             err
);

   localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
   localparam logic [2:0]       CLS_ILL  = 3'd5;

   logic [9:0]       bundle_s;
   logic [2:0]       dec_class_s;
   logic [5:0]       dec_code_s;
   logic [5:0]       cnt_en_s;
   logic             freeze_s;
   logic [CNT_W-1:0] sel_data_s;

   logic             op_valid_r;
   logic [5:0]       op_code_r;
   logic [2:0]       op_class_r;
   logic [CNT_W-1:0] cnt_r [0:5];
   logic [CNT_W-1:0] cnt_data_r;
   logic             err_r;

   assign bundle_s = {RegDst, ALUsrc, Memto_Reg, RegWrite, RegRead,
                      MemWrite, Branch, Jump, ALUop};

   // Pattern-match the bundle back to its opcode; '?' marks don't-care bits.
   always_comb begin
      dec_class_s = CLS_ILL;
      dec_code_s  = 6'b111111;
      casez (bundle_s)
         10'b1001000010: begin dec_class_s = 3'd0; dec_code_s = 6'b000000; end
         10'b0111100000: begin dec_class_s = 3'd1; dec_code_s = 6'b100011; end
         10'b?1?0010000: begin dec_class_s = 3'd2; dec_code_s = 6'b101011; end
         10'b?0?0001001: begin dec_class_s = 3'd3; dec_code_s = 6'b000100; end
         10'b???00001??: begin dec_class_s = 3'd4; dec_code_s = 6'b000010; end
         default:        begin dec_class_s = CLS_ILL; dec_code_s = 6'b111111; end
      endcase
   end

   // Trap mode freezes the legal-class counters while the error flag is up.
   always_comb begin
`ifdef CTL_CLASSIFIER_TRAP_EN
      freeze_s = err_r;
`else
      freeze_s = 1'b0;
`endif
   end

   // One-hot counter enable; a clear in the same cycle swallows the bundle.
   always_comb begin
      cnt_en_s = 6'b000000;
      for (int i = 0; i < 6; i++) begin
         if (ctl_valid && !cnt_clr && (dec_class_s == 3'(i)) &&
             ((dec_class_s == CLS_ILL) || !freeze_s)) begin
            cnt_en_s[i] = 1'b1;
         end else begin
            cnt_en_s[i] = 1'b0;
         end
      end
   end

   // Read mux over the current (pre-update) counter values.
   always_comb begin
      sel_data_s = CNT_ZERO;
      case (cnt_sel)
         3'd0:    sel_data_s = cnt_r[0];
         3'd1:    sel_data_s = cnt_r[1];
         3'd2:    sel_data_s = cnt_r[2];
         3'd3:    sel_data_s = cnt_r[3];
         3'd4:    sel_data_s = cnt_r[4];
         3'd5:    sel_data_s = cnt_r[5];
         default: sel_data_s = CNT_ZERO;
      endcase
   end

   // Decode result register; opcode/class hold while no bundle arrives.
   always_ff @(posedge clk) begin
      if (rst) begin
         op_valid_r <= 1'b0;
         op_code_r  <= 6'b000000;
         op_class_r <= 3'd0;
      end else begin
         op_valid_r <= ctl_valid;
         if (ctl_valid) begin
            op_code_r  <= dec_code_s;
            op_class_r <= dec_class_s;
         end else begin
            op_code_r  <= op_code_r;
            op_class_r <= op_class_r;
         end
      end
   end

   // Per-class saturating counters.
   always_ff @(posedge clk) begin
      if (rst || cnt_clr) begin
         for (int i = 0; i < 6; i++) begin
            cnt_r[i] <= CNT_ZERO;
         end
      end else begin
         for (int i = 0; i < 6; i++) begin
            if (cnt_en_s[i] && (cnt_r[i] != CNT_MAX)) begin
               cnt_r[i] <= cnt_r[i] + {{(CNT_W-1){1'b0}}, 1'b1};
            end
         end
      end
   end

   // Registered counter readback.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_data_r <= CNT_ZERO;
      end else begin
         cnt_data_r <= sel_data_s;
      end
   end

   // Sticky illegal-bundle flag (constant zero without trap mode).
   always_ff @(posedge clk) begin
      if (rst || cnt_clr) begin
         err_r <= 1'b0;
      end else begin
`ifdef CTL_CLASSIFIER_TRAP_EN
         if (ctl_valid && (dec_class_s == CLS_ILL)) begin
            err_r <= 1'b1;
         end
`else
         err_r <= 1'b0;
`endif
      end
   end

   assign op_valid = op_valid_r;
   assign op_code  = op_code_r;
   assign op_class = op_class_r;
   assign cnt_data = cnt_data_r;
   assign err      = err_r;

endmodule
